// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Instruction fetch queue. Issues one-word read requests to a
//               fixed one-cycle-latency memory, buffers returned words with
//               their byte addresses in a DEPTH-entry FIFO, and presents the
//               head entry to a valid/ready consumer. A flush redirects the
//               fetch stream and discards everything buffered or in flight.
//
// Ports       : clk        - clock, all state updates on the rising edge
//               resetb     - asynchronous active-low reset
//               flush      - redirect request (wins over push and pop)
//               flush_pc   - redirect byte address, bit 0 ignored
//               rready     - memory read request (combinational)
//               raddr      - halfword read address, fetch_pc[31:1]
//               rresp      - read data valid, one cycle after rready
//               rdata      - 4 bytes starting at the requested address
//               inst_valid - head entry available
//               inst_ready - consumer accept
//               inst       - head instruction word
//               inst_pc    - byte address of the head instruction word
//
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        rready,
  output logic [31:1] raddr,
  input  logic        rresp,
  input  logic [31:0] rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  // Pointer width is log2(DEPTH) so pointers wrap for free; the occupancy
  // counter needs one extra bit to represent a full queue.
  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W:0] c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]        r_fetch_pc;     // next byte address to request
  logic [31:0]        r_inflight_pc;  // byte address of the request in flight
  logic               r_pending;      // a request was issued last cycle
  logic               r_drop;         // discard the next response
  logic [c_CNT_W-1:0] r_count;        // number of valid FIFO entries
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;

  // FIFO storage carries no reset; validity is tracked by r_count alone.
  logic [31:0]        r_mem_pc   [DEPTH];
  logic [31:0]        r_mem_data [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [c_CNT_W:0]   w_committed;
  logic               w_rready;
  logic               w_push;
  logic               w_pop;
  logic               w_unused_flush_pc0;

  // Only bits [31:1] of the redirect address are meaningful.
  assign w_unused_flush_pc0 = flush_pc[0];

  // Slots already spoken for: buffered entries plus the response that is
  // still on its way. A pop in the same cycle is deliberately not credited,
  // which keeps rready off the consumer's ready path and guarantees a
  // response always finds a free slot.
  assign w_committed = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_pending};

  // resetb gates the request so rready is low for the whole reset interval,
  // independent of the clock.
  assign w_rready = resetb && !flush && (w_committed < c_DEPTH_EXT);

  // A response is only meaningful if it answers a request we still care
  // about: one was issued, it was not cancelled by an earlier flush, and it
  // does not collide with a flush this cycle.
  assign w_push = rresp && r_pending && !r_drop && !flush;

  assign inst_valid = (r_count != '0);
  assign w_pop      = inst_valid && inst_ready && !flush;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_fetch_pc    <= {RESET_PC[31:1], 1'b0};
      r_inflight_pc <= '0;
      r_pending     <= 1'b0;
      r_drop        <= 1'b0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      // rready is forced low on a flush, so pending clears in that case too.
      r_pending <= w_rready;

      // drop lives for exactly one cycle after a flush that caught a request
      // in flight; any response landing in that cycle is discarded.
      r_drop <= flush ? r_pending : 1'b0;

      if (flush) begin
        r_fetch_pc <= {flush_pc[31:1], 1'b0};
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_rready) begin
          r_inflight_pc <= r_fetch_pc;
          r_fetch_pc    <= r_fetch_pc + 32'd4;
        end

        if (w_push) begin
          r_wptr <= r_wptr + c_PTR_W'(1);
        end

        if (w_pop) begin
          r_rptr <= r_rptr + c_PTR_W'(1);
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wptr]   <= r_inflight_pc;
      r_mem_data[r_wptr] <= rdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rready  = w_rready;
  assign raddr   = r_fetch_pc[31:1];

  // Head entry; contents are meaningless while inst_valid is low.
  assign inst    = r_mem_data[r_rptr];
  assign inst_pc = r_mem_pc[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Self-checking bench for ifetch_queue. A memory model answers
//               every request one cycle later with (address ^ key). Stimulus
//               pushes the hand-computed {pc, word} stream it expects into a
//               scoreboard queue; an independent monitor pops and compares on
//               every accepted head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetb;
  logic        flush;
  logic [31:0] flush_pc;
  logic        rready;
  logic [31:1] raddr;
  logic        rresp;
  logic [31:0] rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int checks   = 0;
  int failures = 0;

  logic [31:0] key = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .rready     (rready),
    .raddr      (raddr),
    .rresp      (rresp),
    .rdata      (rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] pc);
    exp_q.push_back({pc, pc ^ key});
  endtask

  // Memory: sample the request before the edge, answer just after it.
  initial begin : mem_model
    logic        m_req;
    logic [31:0] m_addr;
    rresp = 1'b0;
    rdata = 32'h0;
    forever begin
      @(negedge clk);
      m_req  = rready;
      m_addr = {raddr, 1'b0};
      @(posedge clk);
      #1;
      rresp = m_req;
      rdata = m_addr ^ key;
    end
  end

  // Monitor: compare every accepted head entry against the scoreboard, and
  // flag any push into a full queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetb && !flush && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual_pc=%h required=none", inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_inst_pc", inst_pc, e.pc);
          chk("sb_inst", inst, e.data);
        end
      end
      if (resetb && dut.r_count == DEPTH) begin
        chk("push_when_full", {31'b0, dut.w_push}, 32'h0);
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          pulses;
    logic [31:0] paddr;

    resetb     = 1'b0;
    flush      = 1'b0;
    flush_pc   = 32'h0;
    inst_ready = 1'b1;

    // ---- Reset state ----
    repeat (3) @(negedge clk);
    chk("reset_rready", {31'b0, rready}, 32'h0);
    chk("reset_inst_valid", {31'b0, inst_valid}, 32'h0);

    // ---- Streaming from reset, word = address ----
    tick();
    resetb = 1'b1;
    for (int i = 0; i < 8; i++) expect_word(32'(4 * i));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_rready", {31'b0, rready}, 32'h1);
      chk("t1_raddr", {raddr, 1'b0}, 32'(4 * i));
      chk("t1_valid", {31'b0, inst_valid}, {31'b0, (i >= 2)});
      tick();
    end
    inst_ready = 1'b0;
    resetb     = 1'b0;
    key        = 32'h5A5A_0000;
    @(negedge clk);
    chk("t1_drained", 32'(exp_q.size()), 32'h0);
    tick();
    tick();

    // ---- Fill with consumer stalled ----
    resetb = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rready) begin
        pulses++;
        if (pulses <= DEPTH) chk("t2_raddr", {raddr, 1'b0}, 32'(4 * (pulses - 1)));
      end
      tick();
    end
    chk("t2_pulses", 32'(pulses), 32'(DEPTH));
    chk("t2_rready_low", {31'b0, rready}, 32'h0);
    chk("t2_count", 32'(dut.r_count), 32'(DEPTH));
    chk("t2_valid", {31'b0, inst_valid}, 32'h1);
    chk("t2_head_pc", inst_pc, 32'h0);
    chk("t2_head_inst", inst, 32'h0 ^ key);

    // One accept cycle must yield exactly one new request, for 0x10.
    expect_word(32'h0);
    pulses = 0;
    paddr  = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      inst_ready = (i == 0);
      @(negedge clk);
      if (rready) begin
        pulses++;
        paddr = {raddr, 1'b0};
      end
      tick();
    end
    chk("t2_one_pulse", 32'(pulses), 32'h1);
    chk("t2_one_addr", paddr, 32'h10);

    // ---- Drain from full with continuous accept, across pointer wrap ----
    for (int i = 1; i <= 12; i++) expect_word(32'(4 * i));
    inst_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t3_valid", {31'b0, inst_valid}, 32'h1);
      tick();
    end
    chk("t3_drained", 32'(exp_q.size()), 32'h0);

    // ---- Flush with a request in flight, odd redirect address ----
    flush    = 1'b1;
    flush_pc = 32'h103;
    @(negedge clk);
    chk("t4_rready_flush", {31'b0, rready}, 32'h0);
    tick();
    flush = 1'b0;
    expect_word(32'h102);
    expect_word(32'h106);
    expect_word(32'h10A);
    expect_word(32'h10E);
    @(negedge clk);
    chk("t4_rready", {31'b0, rready}, 32'h1);
    chk("t4_raddr", {raddr, 1'b0}, 32'h102);
    chk("t4_valid0", {31'b0, inst_valid}, 32'h0);
    tick();
    @(negedge clk);
    chk("t4_valid1", {31'b0, inst_valid}, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_valid", {31'b0, inst_valid}, 32'h1);
      tick();
    end

    // ---- Flush colliding with accept and response ----
    chk("t5_drained", 32'(exp_q.size()), 32'h0);
    flush    = 1'b1;
    flush_pc = 32'h200;
    expect_word(32'h200);
    expect_word(32'h204);
    expect_word(32'h208);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_valid0", {31'b0, inst_valid}, 32'h0);
    tick();
    @(negedge clk);
    chk("t5_valid1", {31'b0, inst_valid}, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_valid", {31'b0, inst_valid}, 32'h1);
      tick();
    end

    // ---- Asynchronous reset mid-stream ----
    chk("t6_pre_drained", 32'(exp_q.size()), 32'h0);
    #2;
    resetb = 1'b0;
    #1;
    chk("t6_rready_async", {31'b0, rready}, 32'h0);
    chk("t6_valid_async", {31'b0, inst_valid}, 32'h0);
    chk("t6_raddr_async", {raddr, 1'b0}, 32'h0);
    tick();
    tick();
    resetb = 1'b1;
    for (int i = 0; i < 3; i++) expect_word(32'(4 * i));
    @(negedge clk);
    chk("t6_rready", {31'b0, rready}, 32'h1);
    chk("t6_raddr", {raddr, 1'b0}, 32'h0);
    tick();
    repeat (4) tick();
    inst_ready = 1'b0;
    @(negedge clk);
    chk("t6_drained", 32'(exp_q.size()), 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
